// File: rtl/uart_frame_ctrl_pkg.sv
// Shared definitions for the UART frame controller.
//   state_e      : FSM state encoding (3 bits)
//   ERR_*        : err_code values reported with a frame_err pulse
//   SOF_DEFAULT  : default start-of-frame marker byte
package uart_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHECK   = 3'd3,
    ST_DRAIN   = 3'd4
  } state_e;

  localparam logic [1:0] ERR_TIMEOUT = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CHK     = 2'b10;
  localparam logic [1:0] ERR_OVR     = 2'b11;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_ctrl_buf.sv
// Payload store for one frame: DEPTH x 8 register file.
// Ports:
//   clk          : system clock
//   we/waddr/wdata : synchronous write port
//   raddr/rdata  : combinational read port
// Contents are intentionally not reset; only bytes written by the
// current frame are ever read back.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_frame_ctrl.sv
// UART frame controller: parses SOF, LEN, payload, CHK frames from the
// UART receiver byte stream and forwards the payload only after the
// checksum (XOR of LEN and all payload bytes) has passed.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   rx_done_tick, rx_data : one-cycle strobe with the received byte
//   out_valid/out_ready   : payload stream handshake; a byte transfers on a
//                           clock edge where both are 1. While out_valid=1
//                           and out_ready=0, out_data/out_last hold steady.
//   out_data, out_last    : payload byte (0 when idle), final-byte flag
//   frame_ok, frame_err   : registered one-cycle result pulses
//   err_code              : cause of the latest frame_err, held
module uart_frame_ctrl
  import uart_frame_ctrl_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE    = SOF_DEFAULT,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam int LW  = $clog2(MAX_LEN + 1);
  localparam int TW  = $clog2(TIMEOUT_CYC);
  localparam int BAW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [LW-1:0] ONE_L     = LW'(1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

  state_e        state_q,     state_d;
  logic [LW-1:0] len_q,       len_d;
  logic [LW-1:0] wr_cnt_q,    wr_cnt_d;
  logic [LW-1:0] rd_cnt_q,    rd_cnt_d;
  logic [TW-1:0] to_cnt_q,    to_cnt_d;
  logic [7:0]    chk_q,       chk_d;
  logic          frame_ok_q,  frame_ok_d;
  logic          frame_err_q, frame_err_d;
  logic [1:0]    err_code_q,  err_code_d;

  logic          buf_we;
  logic [7:0]    buf_rdata;
  logic          timed_out;
  logic          in_frame;
  logic          last_byte;

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (BAW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_cnt_q[BAW-1:0]),
    .wdata (rx_data),
    .raddr (rd_cnt_q[BAW-1:0]),
    .rdata (buf_rdata)
  );

  assign in_frame  = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) ||
                     (state_q == ST_CHECK);
  assign last_byte = (rd_cnt_q == len_q - ONE_L);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_HUNT;
      len_q       <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      to_cnt_q    <= '0;
      chk_q       <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_TIMEOUT;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      to_cnt_q    <= to_cnt_d;
      chk_q       <= chk_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    to_cnt_d    = to_cnt_q;
    chk_d       = chk_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    buf_we      = 1'b0;
    timed_out   = 1'b0;

    // Inter-byte idle counter. It stops at TO_LAST because reaching it
    // ends the frame, so it can never wrap. A tick on the expiry cycle
    // clears it and wins over the timeout.
    if (in_frame) begin
      if (rx_done_tick) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == TO_LAST) begin
        timed_out = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end else begin
      to_cnt_d = '0;
    end

    case (state_q)
      ST_HUNT: begin
        if (rx_done_tick && (rx_data == SOF_BYTE)) begin
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (rx_done_tick) begin
          if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = ST_HUNT;
          end else begin
            len_d    = rx_data[LW-1:0];
            chk_d    = rx_data;
            wr_cnt_d = '0;
            state_d  = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (rx_done_tick) begin
          buf_we   = 1'b1;
          chk_d    = chk_q ^ rx_data;
          wr_cnt_d = wr_cnt_q + ONE_L;
          if (wr_cnt_q == len_q - ONE_L) begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (rx_done_tick) begin
          if (rx_data == chk_q) begin
            frame_ok_d = 1'b1;
            rd_cnt_d   = '0;
            state_d    = ST_DRAIN;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CHK;
            state_d     = ST_HUNT;
          end
        end
      end
      ST_DRAIN: begin
        // Bytes arriving while the previous payload drains have nowhere
        // to go; they are dropped and reported, even a SOF.
        if (rx_done_tick) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_OVR;
        end
        if (out_ready) begin
          rd_cnt_d = rd_cnt_q + ONE_L;
          if (last_byte) begin
            state_d = ST_HUNT;
          end
        end
      end
      default: begin
        state_d = ST_HUNT;
      end
    endcase

    // Only reachable without a tick, so no other branch fired this cycle.
    if (timed_out) begin
      frame_err_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
      state_d     = ST_HUNT;
    end
  end

  assign out_valid = (state_q == ST_DRAIN);
  assign out_data  = out_valid ? buf_rdata : 8'd0;
  assign out_last  = out_valid && last_byte;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Bench for uart_frame_ctrl: directed scenarios followed by random frames.
// Expected payload bytes and pulse counts come from a frame-level model of
// the protocol (length rule, XOR checksum, store-and-forward).
module tb_uart_frame_ctrl;

  localparam int MAXL = 16;
  localparam int TCYC = 64;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;

  uart_frame_ctrl #(
    .SOF_BYTE    (8'hA5),
    .MAX_LEN     (MAXL),
    .TIMEOUT_CYC (TCYC)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .frame_ok     (frame_ok),
    .frame_err    (frame_err),
    .err_code     (err_code)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int         total = 0;
  int         bad = 0;
  int         ok_cnt = 0;
  int         err_cnt = 0;
  logic [8:0] exp_q[$];   // {last, data}
  logic [7:0] pl_q[$];
  logic [8:0] mon_e;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'd0;
  logic       prev_last = 1'b0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: samples on the falling edge, inputs change just after
  // the rising edge, so everything seen here is stable.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (frame_ok) ok_cnt++;
      if (frame_err) err_cnt++;
      if (frame_ok || frame_err) check("pulse_excl", 32'(frame_ok & frame_err), 0);
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 1);
        check("hold_data", 32'(out_data), 32'(prev_data));
        check("hold_last", 32'(out_last), 32'(prev_last));
      end
      if (!out_valid) check("idle_zero", 32'({out_last, out_data}), 0);
      if (out_valid && out_ready) begin
        check("out_avail", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(mon_e[7:0]));
          check("out_last", 32'(out_last), 32'(mon_e[8]));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_byte(input logic [7:0] b);
    rx_done_tick = 1'b1;
    rx_data      = b;
    cyc1();
    rx_done_tick = 1'b0;
  endtask

  task automatic gap(input int max_gap);
    repeat ($urandom_range(0, max_gap)) cyc1();
  endtask

  task automatic push_payload(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), pl_q[i]});
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (exp_q.size() > 0 && n < bound) begin
      out_ready = 1'($urandom_range(0, 1));
      cyc1();
      n++;
    end
    check("drain_done", 32'(exp_q.size()), 0);
    out_ready = 1'b1;
  endtask

  // Sends one complete frame using pl_q as payload; chk_flip != 0 corrupts
  // the checksum. Expected outcome is derived from the frame rules.
  task automatic send_frame(input logic [7:0] len_b, input logic [7:0] chk_flip,
                            input int max_gap);
    int         ok0 = ok_cnt;
    int         err0 = err_cnt;
    int         exp_ok;
    int         exp_err;
    logic [1:0] exp_code;
    logic [7:0] x;
    tick_byte(8'hA5); gap(max_gap);
    tick_byte(len_b); gap(max_gap);
    if (len_b == 8'd0 || int'(len_b) > MAXL) begin
      exp_ok = 0; exp_err = 1; exp_code = 2'b01;
    end else begin
      x = len_b;
      for (int i = 0; i < int'(len_b); i++) begin
        tick_byte(pl_q[i]);
        x = x ^ pl_q[i];
        gap(max_gap);
      end
      if (chk_flip == 8'd0) begin
        exp_ok = 1; exp_err = 0; exp_code = 2'b00;
        push_payload(int'(len_b));
      end else begin
        exp_ok = 0; exp_err = 1; exp_code = 2'b10;
      end
      tick_byte(x ^ chk_flip);
    end
    drain(400);
    cyc1();
    cyc1();
    check("frame_ok_cnt", 32'(ok_cnt - ok0), 32'(exp_ok));
    check("frame_err_cnt", 32'(err_cnt - err0), 32'(exp_err));
    if (exp_err != 0) check("err_code", 32'(err_code), 32'(exp_code));
  endtask

  task automatic set_pl_abc();
    pl_q.delete();
    pl_q.push_back(8'h11);
    pl_q.push_back(8'h22);
    pl_q.push_back(8'h33);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin : main
    int ok0;
    int err0;
    int first_k;
    logic [7:0] len_b;
    logic [7:0] flip;

    // reset state
    #12;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_last", 32'(out_last), 0);
    check("rst_ok", 32'(frame_ok), 0);
    check("rst_err", 32'(frame_err), 0);
    check("rst_code", 32'(err_code), 0);
    #10 reset_n = 1'b1;
    out_ready = 1'b1;
    cyc1();

    // good frame, full-rate consumer
    set_pl_abc();
    ok0 = ok_cnt;
    push_payload(3);
    tick_byte(8'hA5); tick_byte(8'h03);
    tick_byte(8'h11); tick_byte(8'h22); tick_byte(8'h33);
    tick_byte(8'h03);
    check("g_v0", 32'({out_valid, out_last, out_data}), 32'({2'b10, 8'h11}));
    cyc1();
    check("g_v1", 32'({out_valid, out_last, out_data}), 32'({2'b10, 8'h22}));
    cyc1();
    check("g_v2", 32'({out_valid, out_last, out_data}), 32'({2'b11, 8'h33}));
    cyc1();
    check("g_idle", 32'(out_valid), 0);
    cyc1();
    check("g_ok_once", 32'(ok_cnt - ok0), 1);

    // bad checksum (04 instead of 03), then a good frame
    set_pl_abc();
    send_frame(8'd3, 8'h07, 0);
    send_frame(8'd3, 8'h00, 0);

    // bad length 0 and 17, trailing junk ignored
    send_frame(8'h00, 8'h00, 0);
    err0 = err_cnt;
    tick_byte(8'h11); tick_byte(8'h22); cyc1(); cyc1();
    check("junk_ignored0", 32'(err_cnt - err0), 0);
    send_frame(8'h11, 8'h00, 0);
    err0 = err_cnt; ok0 = ok_cnt;
    tick_byte(8'h03); tick_byte(8'h44); cyc1(); cyc1();
    check("junk_ignored1", 32'((err_cnt - err0) + (ok_cnt - ok0)), 0);

    // timeout: A5 02 AA then silence
    err0 = err_cnt;
    tick_byte(8'hA5); tick_byte(8'h02); tick_byte(8'hAA);
    first_k = -1;
    for (int k = 1; k <= TCYC + 4 && first_k < 0; k++) begin
      cyc1();
      if (frame_err) first_k = k;
    end
    check("timeout_at", 32'(first_k), TCYC);
    check("timeout_code", 32'(err_code), 0);
    cyc1(); cyc1();
    check("timeout_once", 32'(err_cnt - err0), 1);

    // tick on the expiry cycle wins over the timeout
    err0 = err_cnt; ok0 = ok_cnt;
    tick_byte(8'hA5); tick_byte(8'h02); tick_byte(8'hAA);
    repeat (TCYC - 1) cyc1();
    exp_q.push_back({1'b0, 8'hAA});
    exp_q.push_back({1'b1, 8'hBB});
    tick_byte(8'hBB);
    tick_byte(8'h02 ^ 8'hAA ^ 8'hBB);
    drain(100);
    cyc1(); cyc1();
    check("late_tick_no_err", 32'(err_cnt - err0), 0);
    check("late_tick_ok", 32'(ok_cnt - ok0), 1);

    // backpressure and overrun
    set_pl_abc();
    err0 = err_cnt; ok0 = ok_cnt;
    out_ready = 1'b0;
    push_payload(3);
    tick_byte(8'hA5); tick_byte(8'h03);
    tick_byte(8'h11); tick_byte(8'h22); tick_byte(8'h33);
    tick_byte(8'h03);
    for (int i = 0; i < 20; i++) begin
      check("bp_valid", 32'(out_valid), 1);
      check("bp_data", 32'(out_data), 32'h11);
      if (i == 10) tick_byte(8'h55);
      else cyc1();
    end
    check("ovr_err", 32'(err_cnt - err0), 1);
    check("ovr_code", 32'(err_code), 3);
    drain(100);
    cyc1(); cyc1();
    check("bp_ok", 32'(ok_cnt - ok0), 1);
    check("bp_err_total", 32'(err_cnt - err0), 1);

    // async reset mid-payload
    err0 = err_cnt; ok0 = ok_cnt;
    tick_byte(8'hA5); tick_byte(8'h05); tick_byte(8'h01); tick_byte(8'h02);
    #2 reset_n = 1'b0;
    #1;
    check("arst_out", 32'({out_valid, out_last, out_data}), 0);
    check("arst_pulse", 32'({frame_ok, frame_err}), 0);
    check("arst_code", 32'(err_code), 0);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    cyc1(); cyc1();
    check("arst_no_pulse", 32'((err_cnt - err0) + (ok_cnt - ok0)), 0);
    set_pl_abc();
    send_frame(8'd3, 8'h00, 0);

    // random frames with random gaps and random consumer readiness
    for (int f = 0; f < 25; f++) begin
      case ($urandom_range(0, 9))
        0:       len_b = 8'd0;
        1:       len_b = 8'($urandom_range(MAXL + 1, 255));
        default: len_b = 8'($urandom_range(1, MAXL));
      endcase
      flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      pl_q.delete();
      for (int i = 0; i < MAXL; i++) pl_q.push_back(8'($urandom_range(0, 255)));
      send_frame(len_b, flip, 3);
    end

    check("final_q_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
